tensor_wb_serializer: RTL

- Sits directly downstream of the tensor dot-product unit. It accepts a completed 4x4 FP32 D tile and its warp id in a single handshake.
- It then streams the tile to the commit/writeback path as a sequence of row-group beats, so writeback datapath width is decoupled from tile width.
- It holds one tile. It can accept the next tile in the same cycle the last beat of the current tile fires.

---
 rtl/tensor_wb_serializer.sv | 93 +++++++++
 1 files changed

// File: rtl/tensor_wb_serializer.sv
// tensor_wb_serializer: holds one 4x4 FP32 D tile and streams it to writeback as row-group beats.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   valid_in     upstream D tile valid
//   ready_in     tile can be accepted this cycle (combinational from ready_out)
//   D_tile       [row][col][fp32] result tile
//   D_wid        warp id of D_tile
//   valid_out    beat valid
//   ready_out    downstream accepts the beat
//   data_out     rows [beat*ROWS_PER_BEAT +: ROWS_PER_BEAT] of the held tile
//   wid_out      warp id of the held tile
//   beat_idx     current beat number, 0..BEATS-1
//   last_out     final beat of the held tile
//   stall_cycles free-running count of valid_out && !ready_out cycles
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tensor_wb_serializer #(
   parameter int ROWS_PER_BEAT = 1,
   parameter int PERF_WIDTH    = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  valid_in,
   output logic                                  ready_in,
   input  logic [3:0][3:0][31:0]                 D_tile,
   input  logic [`NW_WIDTH-1:0]                  D_wid,
   output logic                                  valid_out,
   input  logic                                  ready_out,
   output logic [ROWS_PER_BEAT-1:0][3:0][31:0]   data_out,
   output logic [`NW_WIDTH-1:0]                  wid_out,
   output logic [1:0]                            beat_idx,
   output logic                                  last_out,
   output logic [PERF_WIDTH-1:0]                 stall_cycles
);
   localparam int         BEATS = 4 / ROWS_PER_BEAT;
   localparam logic [1:0] LAST  = 2'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 r_state;
   logic [1:0]             r_cnt;
   logic [3:0][3:0][31:0]  r_tile;
   logic [`NW_WIDTH-1:0]   r_wid;
   logic [PERF_WIDTH-1:0]  r_stall;
   logic                   w_fire_in;
   logic                   w_fire_out;
   logic [1:0]             w_row;

   assign valid_out    = r_state == SEND;
   assign last_out     = valid_out && r_cnt == LAST;
   assign w_fire_out   = valid_out && ready_out;
   // A new tile may slide in behind the last beat in the same cycle, so no bubble between tiles.
   assign ready_in     = reset && (r_state == IDLE || (w_fire_out && last_out));
   assign w_fire_in    = valid_in && ready_in;
   assign w_row        = 2'(r_cnt * ROWS_PER_BEAT);
   assign data_out     = r_tile[w_row +: ROWS_PER_BEAT];
   assign wid_out      = r_wid;
   assign beat_idx     = r_cnt;
   assign stall_cycles = r_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_tile  <= '0;
         r_wid   <= '0;
         r_stall <= '0;
      end else begin
         if (valid_out && !ready_out) r_stall <= r_stall + 1'b1;
         // fire_in in SEND implies the last beat is firing, so this also covers the reload case.
         if (w_fire_in) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_tile  <= D_tile;
            r_wid   <= D_wid;
         end else if (w_fire_out) begin
            r_state <= last_out ? IDLE : SEND;
            r_cnt   <= last_out ? 2'd0 : r_cnt + 2'd1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (!reset)
      valid_out && !ready_out |=> $stable(data_out) && $stable(wid_out));

   if (!(ROWS_PER_BEAT inside {1, 2, 4})) begin : g_bad_rpb
      $error("ROWS_PER_BEAT must be 1, 2 or 4");
   end
endmodule
